// File: rtl/keypad_pkg.sv
// Shared keypad constants, scan FSM state type and key-code helpers used by
// the scan controller, its column synchronizer and the bus interface.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    // One-hot key code: bit index = row * NUM_COLS + col.
    function automatic logic [KEY_W-1:0] key_onehot(input logic [1:0] row, input logic [1:0] col);
        logic [KEY_W-1:0] v;
        v = {KEY_W{1'b0}};
        v[{row, col}] = 1'b1;
        return v;
    endfunction

    // Active-low pattern with only line 'idx' pulled low; used both for the
    // row drive and for recognising an exclusively-low column.
    function automatic logic [3:0] low_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad bus: column sense from the matrix, row drive back to it, and the
// accepted-key outputs that feed the keypress storage block directly.
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] col_in;
    logic [NUM_ROWS-1:0] row_out;
    logic                new_key;
    logic [KEY_W-1:0]    key_pressed_value;

    // Controller side
    modport master (
        input  col_in,
        output row_out,
        output new_key,
        output key_pressed_value
    );

    // Keypad / consumer side
    modport slave (
        output col_in,
        input  row_out,
        input  new_key,
        input  key_pressed_value
    );
endinterface

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous keypad columns. Flops reset to
// all-high (no key pressed) so the scanner sees an idle keypad after reset.
module col_sync
    import keypad_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_COLS-1:0] col_i,
    output logic [NUM_COLS-1:0] col_o
);

    logic [NUM_COLS-1:0] meta_q;
    logic [NUM_COLS-1:0] sync_q;

    // Two-stage resynchronisation of the column lines into the clk domain.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= col_i;
            sync_q <= meta_q;
        end
    end

    assign col_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce.
// Drives one row low at a time, latches a single-key hit, debounces it, pulses
// new_key with the one-hot key code, then waits for a debounced release.
// Optional build macro KEYPAD_COL_SYNC_EN inserts a two-flop synchronizer on
// the column inputs (2 cycles of extra latency); without it col_in is used raw.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scan_ctrl_if.master kp
);

    localparam int SCAN_CW = $clog2(SCAN_CYCLES) + 1;
    localparam int DEB_CW  = $clog2(DEBOUNCE_CYCLES) + 1;

    scan_state_t          state_q;
    logic [1:0]           row_q;
    logic [1:0]           col_q;
    logic [SCAN_CW-1:0]   scan_cnt_q;
    logic [DEB_CW-1:0]    deb_cnt_q;
    logic [NUM_ROWS-1:0]  row_out_q;
    logic                 new_key_q;
    logic [KEY_W-1:0]     key_val_q;

    logic [NUM_COLS-1:0]  col_s;
    logic                 single_low_s;
    logic [1:0]           low_col_s;
    logic                 scan_done_s;
    logic                 deb_done_s;
    logic                 col_excl_s;
    logic                 all_high_s;

`ifdef KEYPAD_COL_SYNC_EN
    col_sync u_col_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .col_i   (kp.col_in),
        .col_o   (col_s)
    );
`else
    assign col_s = kp.col_in;
`endif

    assign scan_done_s = (scan_cnt_q == SCAN_CW'(SCAN_CYCLES - 1));
    assign deb_done_s  = (deb_cnt_q == DEB_CW'(DEBOUNCE_CYCLES - 1));
    assign col_excl_s  = (col_s == low_pattern(col_q));
    assign all_high_s  = (col_s == 4'b1111);

    // Decode a sampled column word into "exactly one low" plus its index.
    always_comb begin
        single_low_s = 1'b0;
        low_col_s    = 2'd0;
        case (col_s)
            4'b1110: begin single_low_s = 1'b1; low_col_s = 2'd0; end
            4'b1101: begin single_low_s = 1'b1; low_col_s = 2'd1; end
            4'b1011: begin single_low_s = 1'b1; low_col_s = 2'd2; end
            4'b0111: begin single_low_s = 1'b1; low_col_s = 2'd3; end
            default: begin single_low_s = 1'b0; low_col_s = 2'd0; end
        endcase
    end

    // Scan/debounce FSM; all outputs are registered here. Counters are cleared
    // on every state change and stop at their terminal value, so they never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCAN;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            scan_cnt_q <= {SCAN_CW{1'b0}};
            deb_cnt_q  <= {DEB_CW{1'b0}};
            row_out_q  <= 4'b1110;
            new_key_q  <= 1'b0;
            key_val_q  <= {KEY_W{1'b0}};
        end else begin
            new_key_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (scan_done_s) begin
                        scan_cnt_q <= {SCAN_CW{1'b0}};
                        deb_cnt_q  <= {DEB_CW{1'b0}};
                        if (single_low_s) begin
                            // Row drive stays frozen on the hit row.
                            state_q <= PRESS_DB;
                            col_q   <= low_col_s;
                        end else begin
                            row_q     <= row_q + 2'd1;
                            row_out_q <= low_pattern(row_q + 2'd1);
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + SCAN_CW'(1);
                    end
                end
                PRESS_DB: begin
                    if (col_excl_s) begin
                        if (deb_done_s) begin
                            state_q   <= HELD;
                            deb_cnt_q <= {DEB_CW{1'b0}};
                            new_key_q <= 1'b1;
                            key_val_q <= key_onehot(row_q, col_q);
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_CW'(1);
                        end
                    end else begin
                        // Bounce or extra key: give up and resume at the next row.
                        state_q    <= SCAN;
                        row_q      <= row_q + 2'd1;
                        row_out_q  <= low_pattern(row_q + 2'd1);
                        scan_cnt_q <= {SCAN_CW{1'b0}};
                        deb_cnt_q  <= {DEB_CW{1'b0}};
                    end
                end
                HELD: begin
                    if (all_high_s) begin
                        state_q   <= RELEASE_DB;
                        deb_cnt_q <= {DEB_CW{1'b0}};
                    end else begin
                        state_q <= HELD;
                    end
                end
                RELEASE_DB: begin
                    if (!all_high_s) begin
                        state_q   <= HELD;
                        deb_cnt_q <= {DEB_CW{1'b0}};
                    end else if (deb_done_s) begin
                        state_q    <= SCAN;
                        row_q      <= 2'd0;
                        row_out_q  <= 4'b1110;
                        scan_cnt_q <= {SCAN_CW{1'b0}};
                        deb_cnt_q  <= {DEB_CW{1'b0}};
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DEB_CW'(1);
                    end
                end
                default: begin
                    state_q    <= SCAN;
                    row_q      <= 2'd0;
                    row_out_q  <= 4'b1110;
                    scan_cnt_q <= {SCAN_CW{1'b0}};
                    deb_cnt_q  <= {DEB_CW{1'b0}};
                end
            endcase
        end
    end

    assign kp.row_out           = row_out_q;
    assign kp.new_key           = new_key_q;
    assign kp.key_pressed_value = key_val_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8). A procedural
// reference model walks the keypad behaviour as a sequential program and is
// compared against the DUT every cycle; directed scenarios plus random
// column activity drive the inputs.
module tb_keypad_scan_ctrl;

    localparam int SCAN_CYC = 4;
    localparam int DEB_CYC  = 8;

    logic clk;
    logic reset;

    keypad_scan_ctrl_if kp_if ();

    keypad_scan_ctrl #(
        .SCAN_CYCLES     (SCAN_CYC),
        .DEBOUNCE_CYCLES (DEB_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    bit chk_en   = 1'b0;

    logic [3:0]  m_row = 4'b1110;
    logic        m_new = 1'b0;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  h0 = 4'hF;
    logic [3:0]  h1 = 4'hF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One rising edge: returns the column word the decision logic sees and
    // whether reset was applied on this edge.
    task automatic m_edge(output logic [3:0] c, output bit rst);
        @(posedge clk);
        rst = reset;
`ifdef KEYPAD_COL_SYNC_EN
        if (rst) begin
            h0 = 4'hF; h1 = 4'hF; c = 4'hF;
        end else begin
            c = h1; h1 = h0; h0 = kp_if.col_in;
        end
`else
        c = kp_if.col_in;
`endif
        m_new = 1'b0;
        if (rst) begin
            m_row = 4'b1110;
            m_val = 16'h0000;
        end
    endtask

    // Keypad behaviour from power-up until the next reset edge.
    task automatic mdl_run();
        logic [3:0] c;
        bit rst;
        int row;
        int col;
        int run;
        row = 0;
        forever begin
            m_row = ~(4'b0001 << row);
            for (int k = 0; k < SCAN_CYC; k++) begin
                m_edge(c, rst);
                if (rst) return;
            end
            if ($countones(~c) != 1) begin
                row = (row + 1) % 4;
                continue;
            end
            col = 0;
            for (int j = 0; j < 4; j++) if (c[j] == 1'b0) col = j;
            run = 0;
            while (run < DEB_CYC) begin
                m_edge(c, rst);
                if (rst) return;
                if ($countones(~c) == 1 && c[col] == 1'b0) run++;
                else break;
            end
            if (run < DEB_CYC) begin
                row = (row + 1) % 4;
                continue;
            end
            m_new = 1'b1;
            m_val = 16'h0001 << (row * 4 + col);
            forever begin
                do begin
                    m_edge(c, rst);
                    if (rst) return;
                end while (c != 4'hF);
                run = 0;
                while (run < DEB_CYC) begin
                    m_edge(c, rst);
                    if (rst) return;
                    if (c == 4'hF) run++;
                    else break;
                end
                if (run == DEB_CYC) break;
            end
            row = 0;
        end
    endtask

    initial begin
        forever mdl_run();
    end

    // Per-cycle comparison of DUT outputs with the model, away from the active edge.
    always @(negedge clk) begin
        if (kp_if.new_key === 1'b1) pulse_cnt++;
        if (chk_en) begin
            check_eq("row_out", kp_if.row_out, m_row);
            check_eq("new_key", kp_if.new_key, m_new);
            check_eq("key_val", kp_if.key_pressed_value, m_val);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_row_start(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            prev = m_row;
            @(negedge clk);
            if (m_row == target && prev != target) found = 1'b1;
        end
        if (!found) check_eq("wait_row_timeout", m_row, ~target);
    endtask

    initial begin
        int snap;
        int r;
        int hold;
        reset = 1'b1;
        kp_if.col_in = 4'hF;
        @(negedge clk);
        check_eq("rst_row", kp_if.row_out, 4'b1110);
        check_eq("rst_new", kp_if.new_key, 1'b0);
        check_eq("rst_val", kp_if.key_pressed_value, 16'h0000);
        reset = 1'b0;
        chk_en = 1'b1;

        // Idle scan
        snap = pulse_cnt;
        repeat (64) @(negedge clk);
        check_eq("idle_pulses", pulse_cnt - snap, 0);

        // Clean press of row 2 / col 1
        snap = pulse_cnt;
        wait_row_start(4'b1011);
        kp_if.col_in = 4'b1101;
        repeat (20) @(negedge clk);
        check_eq("clean_val", kp_if.key_pressed_value, 16'h0200);
        kp_if.col_in = 4'hF;
        repeat (20) @(negedge clk);
        check_eq("clean_pulses", pulse_cnt - snap, 1);

        // Bounce during press debounce on row 1, later valid press on row 2
        snap = pulse_cnt;
        wait_row_start(4'b1101);
        kp_if.col_in = 4'b1101;
        repeat (5) @(negedge clk);
        kp_if.col_in = 4'hF;
        @(negedge clk);
        kp_if.col_in = 4'b1101;
        repeat (20) @(negedge clk);
        kp_if.col_in = 4'hF;
        repeat (20) @(negedge clk);
        check_eq("bounce_pulses", pulse_cnt - snap, 1);
        check_eq("bounce_val", kp_if.key_pressed_value, 16'h0200);

        // Two columns low at the row-0 sample: no latch, scan advances
        wait_row_start(4'b1110);
        kp_if.col_in = 4'b1100;
        repeat (4) @(negedge clk);
        check_eq("multi_advance", kp_if.row_out, 4'b1101);
        kp_if.col_in = 4'hF;

        // Key 0 held, then col 3 pressed as well: ignored
        wait_row_start(4'b1110);
        kp_if.col_in = 4'b1110;
        repeat (16) @(negedge clk);
        check_eq("key0_val", kp_if.key_pressed_value, 16'h0001);
        snap = pulse_cnt;
        kp_if.col_in = 4'b0110;
        repeat (10) @(negedge clk);
        check_eq("held_other_pulses", pulse_cnt - snap, 0);

        // Release glitch at release cycle 3, then clean release
        kp_if.col_in = 4'hF;
        repeat (2) @(negedge clk);
        kp_if.col_in = 4'b1110;
        @(negedge clk);
        kp_if.col_in = 4'hF;
        repeat (10) @(negedge clk);
        check_eq("release_row", kp_if.row_out, 4'b1110);
        check_eq("release_pulses", pulse_cnt - snap, 0);

        // Reset while the press debounce counter is at 6
        wait_row_start(4'b1110);
        kp_if.col_in = 4'b1110;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_row", kp_if.row_out, 4'b1110);
        check_eq("mid_rst_new", kp_if.new_key, 1'b0);
        check_eq("mid_rst_val", kp_if.key_pressed_value, 16'h0000);
        kp_if.col_in = 4'hF;
        repeat (30) @(negedge clk);

        // Random column activity with occasional resets
        for (int seg = 0; seg < 220; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                if (r < 40) kp_if.col_in = 4'hF;
                else if (r < 85) kp_if.col_in = ~(4'b0001 << $urandom_range(0, 3));
                else kp_if.col_in = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 24);
                repeat (hold) @(negedge clk);
            end
        end
        kp_if.col_in = 4'hF;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000: clock cycles each row is driven before its columns are sampled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: clock cycles a press or release must remain stable before it is accepted.
REQ-003 Port clk  input  1: single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port col_in  input  4: keypad columns, active-low, pulled up, asynchronous to clk.
REQ-006 Port row_out  output  4: keypad row drive, active-low, at most one bit low at any time.
REQ-007 Port new_key  output  1: one-cycle pulse when a debounced press is accepted.
REQ-008 Port key_pressed_value  output  16: one-hot code of the last accepted key, bit index = row*4 + col.

Function
REQ-009 FSM states SHALL be SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-010 In SCAN, the block SHALL drive row_out = ~(1 << r) for SCAN_CYCLES cycles, then sample the columns on the last cycle of that dwell.
REQ-011 If exactly one sampled column is low, the block SHALL latch r and that column, enter PRESS_DB and freeze row_out.
REQ-012 If no column or more than one column is low, the block SHALL advance r, wrapping 3 to 0, and remain in SCAN.
REQ-013 In PRESS_DB, the block SHALL return to SCAN at the next row on any cycle where the latched column is not exclusively low.
REQ-014 If the latched column stays exclusively low for DEBOUNCE_CYCLES consecutive cycles, the block SHALL assert new_key for exactly one cycle and load key_pressed_value in that same cycle.
REQ-015 After accepting a press, the block SHALL enter HELD.
REQ-016 In HELD, with row_out still frozen, the block SHALL enter RELEASE_DB once all columns read high.
REQ-017 While in HELD, presses of other keys SHALL be ignored and SHALL NOT generate new_key.
REQ-018 In RELEASE_DB, the block SHALL return to HELD if any column goes low.
REQ-019 If all columns stay high for DEBOUNCE_CYCLES consecutive cycles, the block SHALL return to SCAN at row 0.
REQ-020 key_pressed_value SHALL hold its value until the next accepted press; a repeat of the same key SHALL re-pulse new_key with an unchanged value.
REQ-021 new_key SHALL NOT be asserted in two consecutive cycles.
REQ-022 Each counter SHALL be sized $clog2 of its parameter plus 1, SHALL clear on every state entry, and SHALL never wrap.

Reset
REQ-023 On reset, outputs SHALL be row_out = 4'b1110, new_key = 0 and key_pressed_value = 16'h0000; internal state SHALL be state = SCAN, r = 0 and counters = 0.
REQ-024 Reset asserted in any state SHALL take effect at the next rising clk edge; no new_key pulse SHALL be issued in that cycle.

Configuration
REQ-025 With KEYPAD_COL_SYNC_EN defined, col_in SHALL pass through a two-flop synchronizer, adding exactly 2 cycles of latency from col_in to every decision above; the synchronizer flops SHALL reset to 4'b1111.
REQ-026 Without KEYPAD_COL_SYNC_EN, col_in SHALL be used directly, with zero added latency.

Structure
REQ-027 Shared package keypad_pkg SHALL hold the NUM_ROWS = 4 and NUM_COLS = 4 constants, the scan_state_t enum and the key index-to-one-hot function.
REQ-028 One sub-module, col_sync, SHALL implement the REQ-025 synchronizer, instantiated only under KEYPAD_COL_SYNC_EN.
REQ-029 The key_pressed_value and new_key outputs SHALL connect directly to the existing keypress storage block without glue logic.

Verification (SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8, macro undefined)
REQ-030 Idle: reset, then col_in = 4'b1111 for 64 cycles -> row_out cycles 1110, 1101, 1011, 0111, 4 cycles each, wrapping; new_key never asserts.
REQ-031 Clean press: col_in = 4'b1101 held while row 2 is driven -> after 8 stable cycles new_key pulses once and key_pressed_value = 16'h0200.
REQ-032 Bounce: col 1 is low for 5 cycles, high for 1 cycle, then low during debounce -> no pulse from the aborted attempt; exactly one pulse after a later full 8-cycle stable window.
REQ-033 Multi-key: col_in = 4'b1100 at the row-0 sample -> no latch and the scan advances; during HELD on key 0, a press of col 3 -> no new_key.
REQ-034 Release glitch: in RELEASE_DB, col goes low at cycle 3 -> back to HELD with no pulse; a clean release of 8 cycles -> SCAN at row_out = 1110.
REQ-035 Reset mid-PRESS_DB at counter 6 -> the next cycle shows row_out = 1110, new_key = 0 and key_pressed_value = 0; with KEYPAD_COL_SYNC_EN defined, the REQ-031 pulse occurs exactly 2 cycles later.
